uart_tx_arbiter: RTL



---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and sizing for the UART TX FIFO arbiter.
// Optional stalled-grant timeout is enabled with UART_ARB_TIMEOUT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package uart_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 1024;

  // Counter only has to reach cycles-1, so clog2(cycles) bits suffice.
  function automatic int to_cnt_w(int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  localparam int TO_CNT_W = to_cnt_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority search: first set bit of req starting at ptr, wrapping.
// Purely combinational so it can be reused in other bus arbiters.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    found = 1'b0;
    // Walk from the farthest offset back so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        idx   = IDX_W'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART TX FIFO write port.
// Define UART_ARB_TIMEOUT_EN to revoke grants stalled for TIMEOUT_CYCLES.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GID_W          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*`DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [`DATA_WIDTH-1:0]          fifo_wr_data,
  output logic [GID_W-1:0]                grant_id,
  output logic                            busy,
  output logic                            timeout_pulse
);

  localparam int DW = `DATA_WIDTH;

  arb_state_e       state_q, state_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0] pick_idx, next_ptr;
  logic             pick_found, xfer;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = to_cnt_w(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_pulse_q, timeout_pulse_d;
`endif

  rr_pick #(.N(NUM_REQ), .IDX_W(GID_W)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign next_ptr = (int'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + GID_W'(1);

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    req_ready    = '0;
    xfer         = 1'b0;
    fifo_wr_data = '0;
    if (state_q == IDLE) begin
      if (pick_found) begin
        grant_id_d = pick_idx;
        state_d    = GRANTED;
      end
    end else if (!rst) begin
      // Reset drops the grant in the same cycle: no write while rst is high.
      req_ready[grant_id_q] = !fifo_full;
      xfer                  = req_valid[grant_id_q] && !fifo_full;
      fifo_wr_data          = req_data[int'(grant_id_q)*DW +: DW];
      if (xfer && req_last[grant_id_q]) begin
        state_d  = IDLE;
        rr_ptr_d = next_ptr;
      end
    end
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d           = '0;
    timeout_pulse_d = 1'b0;
    if (state_q == GRANTED && !xfer && !fifo_full) begin
      if (int'(cnt_q) >= TIMEOUT_CYCLES - 1) begin
        state_d         = IDLE;
        rr_ptr_d        = next_ptr;
        timeout_pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q           <= '0;
      timeout_pulse_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q           <= cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
`endif
    end
  end

  assign fifo_wr_en = xfer;
  assign busy       = (state_q == GRANTED) && !rst;
  assign grant_id   = grant_id_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_pulse = timeout_pulse_q;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule
